// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted bit sampling, glitch-rejecting start detection,
// parity/framing/break/overrun status and a valid/ready output holding register.
`timescale 1ns/1ps

module uart_rx_param #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_enable_signal,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_signal,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int H     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HM1   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_H     = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [1:0]             sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic                   stop_idx;
  logic                   s0;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   perr_q;
  logic                   ferr_q;

  logic rxs;
  logic rxs_next;
  logic maj;
  logic first_stop_low;
  logic brk_now;

  // The FSM registers act as a second stage alongside sync_q[1]: they capture sync_q[0]
  // on the same edge, so the third vote and the start edge are seen one clock earlier.
  assign rxs      = sync_q[1];
  assign rxs_next = sync_q[0];
  assign maj      = (s0 & rxs) | (s0 & rxs_next) | (rxs & rxs_next);

  assign first_stop_low = stop_idx ? ferr_q : ~maj;
  assign brk_now        = (shreg == '0) && (!PARITY_EN || !par_bit) && first_stop_low;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      stop_idx       <= 1'b0;
      s0             <= 1'b1;
      shreg          <= '0;
      par_bit        <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_done_signal <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      break_det      <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      // NOTE: defaults come first; a later assignment in the frame-completion branch
      // overrides them, which is how completion beats the handshake clear and err_clr.
      rx_done_signal <= 1'b0;
      break_det      <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (err_clr)              overrun_err <= 1'b0;

      if (cnt == CNT_HM1) s0 <= rxs;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_enable_signal && rxs && !rxs_next) begin
            state  <= S_START;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
          end
        end

        S_START: begin
          if (cnt == CNT_H && maj) begin
            state <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= S_DATA;
            idx   <= '0;
          end
        end

        S_DATA: begin
          if (cnt == CNT_H) shreg[idx] <= maj;
          if (cnt == CNT_LAST) begin
            if (idx == IDX_LAST) begin
              state    <= PARITY_EN ? S_PARITY : S_STOP;
              stop_idx <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (cnt == CNT_H) begin
            par_bit <= maj;
            perr_q  <= maj != ((^shreg) ^ PARITY_ODD);
          end
          if (cnt == CNT_LAST) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
          end
        end

        S_STOP: begin
          if (cnt == CNT_H) begin
            if (stop_idx == STOP_LAST) begin
              // Frame completes mid stop bit so a back-to-back start edge is never missed.
              state          <= S_IDLE;
              rx_done_signal <= 1'b1;
              break_det      <= brk_now;
              if (!rx_valid || rx_ready) begin
                rx_data    <= shreg;
                parity_err <= perr_q;
                frame_err  <= ferr_q | ~maj;
                rx_valid   <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              ferr_q <= ferr_q | ~maj;
            end
          end else if (cnt == CNT_LAST) begin
            stop_idx <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 5N2) at 16 clocks/bit,
// with a scoreboard queue of expected words checked on every rx_done_signal pulse.
`timescale 1ns/1ps

module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [1:0] inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_line;
  logic       rx_en;
  logic       rx_ready;
  logic       err_clr;

  logic [7:0] d0;
  logic [7:0] d1;
  logic [4:0] d2;
  logic [2:0] done, valid, perr, ferr, brk, ovr;
  logic [8:0] dat [3];

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt [3] = '{default: 0};

  always #5 clk = ~clk;

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {4'b0, d2};

  uart_rx_param #(.CLKS_PER_BIT(CPB)) dut_8n1 (
    .clk(clk), .rst(rst), .rx_in(rx_line[0]), .rx_enable_signal(rx_en),
    .rx_data(d0), .rx_done_signal(done[0]), .rx_valid(valid[0]), .rx_ready(rx_ready),
    .parity_err(perr[0]), .frame_err(ferr[0]), .break_det(brk[0]),
    .overrun_err(ovr[0]), .err_clr(err_clr)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_8e1 (
    .clk(clk), .rst(rst), .rx_in(rx_line[1]), .rx_enable_signal(rx_en),
    .rx_data(d1), .rx_done_signal(done[1]), .rx_valid(valid[1]), .rx_ready(rx_ready),
    .parity_err(perr[1]), .frame_err(ferr[1]), .break_det(brk[1]),
    .overrun_err(ovr[1]), .err_clr(err_clr)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2)) dut_5n2 (
    .clk(clk), .rst(rst), .rx_in(rx_line[2]), .rx_enable_signal(rx_en),
    .rx_data(d2), .rx_done_signal(done[2]), .rx_valid(valid[2]), .rx_ready(rx_ready),
    .parity_err(perr[2]), .frame_err(ferr[2]), .break_det(brk[2]),
    .overrun_err(ovr[2]), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int sel, input logic v);
    rx_line[sel] = v;
    tick(CPB);
  endtask

  // stops[0] is the first stop bit on the line.
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic par, input logic [1:0] stops,
                            input int nstop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel, data[i]);
    if (par_en) send_bit(sel, par);
    for (int i = 0; i < nstop; i++) send_bit(sel, stops[i]);
    rx_line[sel] = 1'b1;
  endtask

  task automatic expect_frame(input int sel, input logic [8:0] data, input logic pe,
                              input logic fe, input logic bk);
    exp_q.push_back('{inst: 2'(sel), data: data, perr: pe, ferr: fe, brk: bk});
  endtask

  // Scoreboard: every completion pulse pops one expectation and checks the held word.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst && done[i]) begin
        done_cnt[i]++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst",  32'(i),    32'(e.inst));
          check("sb_data",  32'(dat[i]), 32'(e.data));
          check("sb_valid", 32'(valid[i]), 32'd1);
          check("sb_perr",  32'(perr[i]),  32'(e.perr));
          check("sb_ferr",  32'(ferr[i]),  32'(e.ferr));
          check("sb_brk",   32'(brk[i]),   32'(e.brk));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit found;
    int c;

    rst      = 1'b0;
    rx_line  = 3'b111;
    rx_en    = 1'b1;
    rx_ready = 1'b1;
    err_clr  = 1'b0;

    #12;
    check("rst_data",  32'(d0), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_flags", 32'({perr, ferr, brk, ovr}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(5);

    // 8N1 single frame with latency measured from the start edge.
    expect_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1);
      begin
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 400) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (done[0]) found = 1'b1;
        end
        check("lat_8n1", 32'(lat), 32'd155);
        @(negedge clk);
        check("done_one_cycle", 32'(done[0]), 32'd0);
      end
    join
    tick(CPB);

    // Short low pulse from idle must be rejected without any status change.
    c = done_cnt[0];
    rx_line[0] = 1'b0;
    tick(4);
    rx_line[0] = 1'b1;
    tick(40);
    check("glitch_no_done", 32'(done_cnt[0]), 32'(c));
    check("glitch_flags", 32'({perr[0], ferr[0], brk[0], ovr[0]}), 32'h0);
    expect_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1);
    tick(CPB);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    expect_frame(1, 9'h007, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 2'b11, 1);
    expect_frame(1, 9'h007, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 2'b11, 1);
    tick(CPB);

    // Low stop bit, then an all-zero line for a whole frame (break).
    expect_frame(0, 9'h055, 1'b0, 1'b1, 1'b0);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 2'b10, 1);
    tick(CPB);
    expect_frame(0, 9'h000, 1'b0, 1'b1, 1'b1);
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 2'b00, 1);
    tick(CPB);
    check("drain_a", 32'(exp_q.size()), 32'd0);

    // Overrun: second word is dropped while the first is still held.
    rx_ready = 1'b0;
    expect_frame(0, 9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
    expect_frame(0, 9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
    tick(2);
    check("ovr_set",   32'(ovr[0]),   32'd1);
    check("ovr_data",  32'(d0),       32'h11);
    check("ovr_valid", 32'(valid[0]), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    check("valid_drop",  32'(valid[0]), 32'd0);
    check("ovr_sticky",  32'(ovr[0]),   32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ovr_clr", 32'(ovr[0]), 32'd0);
    tick(CPB);

    // 5 data bits, 2 stop bits: back-to-back frames, then a low second stop bit.
    expect_frame(2, 9'h01F, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h01F, 5, 1'b0, 1'b0, 2'b11, 2);
    expect_frame(2, 9'h00A, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h00A, 5, 1'b0, 1'b0, 2'b11, 2);
    expect_frame(2, 9'h015, 1'b0, 1'b1, 1'b0);
    send_frame(2, 9'h015, 5, 1'b0, 1'b0, 2'b01, 2);
    tick(CPB);
    check("drain_b", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the data bits discards the partial word.
    c = done_cnt[0];
    fork
      send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
      begin
        tick(CPB * 4);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_data",  32'(d0), 32'h0);
        check("midrst_valid", 32'(valid[0]), 32'd0);
        check("midrst_flags", 32'({done[0], perr[0], ferr[0], brk[0], ovr[0]}), 32'h0);
      end
    join
    tick(2);
    rst = 1'b1;
    tick(5);
    check("midrst_no_done", 32'(done_cnt[0]), 32'(c));
    expect_frame(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 2'b11, 1);
    tick(CPB);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
